// File: rtl/gpu_pkg.sv
// Shared encodings for the core scheduler, decoder and instruction fetcher.
// Holds the core-state and fetcher-state encodings and the default
// program-memory address/data widths.
package gpu_pkg;

    localparam int DEFAULT_PROGRAM_MEM_ADDR_BITS = 8;
    localparam int DEFAULT_PROGRAM_MEM_DATA_BITS = 16;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    typedef enum logic [2:0] {
        F_IDLE     = 3'b000,
        F_FETCHING = 3'b001,
        F_FETCHED  = 3'b010
    } fetcher_state_t;

endpackage

// File: rtl/instruction_fetcher.sv
// Per-core instruction fetcher: runs the valid/ready handshake with program
// memory and holds the fetched word on `instruction` until the next fetch.
// Optional feature macro: FETCHER_LAST_PC_CACHE_EN adds a one-entry cache
// that skips the memory request when the same PC is fetched again.
//
// state      | meaning
// -----------+------------------------------------------------------------
// F_IDLE     | no request outstanding; waits for the scheduler's FETCH
// F_FETCHING | request on the bus; address/valid held until ready closes it
// F_FETCHED  | instruction valid and stable; waits for DECODE or IDLE
module instruction_fetcher
    import gpu_pkg::*;
#(
    parameter int PROGRAM_MEM_ADDR_BITS = DEFAULT_PROGRAM_MEM_ADDR_BITS,
    parameter int PROGRAM_MEM_DATA_BITS = DEFAULT_PROGRAM_MEM_DATA_BITS
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

    fetcher_state_t state_q;
    fetcher_state_t state_d;

    logic core_is_fetch;
    logic core_is_decode;
    logic core_is_idle;
    logic cache_hit;

    // Load enables for the registered outputs, produced by the output process.
    logic issue_req;
    logic close_req;
    logic accept_word;

    assign core_is_fetch  = (core_state == CORE_FETCH);
    assign core_is_decode = (core_state == CORE_DECODE);
    assign core_is_idle   = (core_state == CORE_IDLE);

`ifdef FETCHER_LAST_PC_CACHE_EN
    logic [PROGRAM_MEM_ADDR_BITS-1:0] cached_pc;
    logic                             cache_valid;

    assign cache_hit = cache_valid && (current_pc == cached_pc);

    // Tag tracks the PC of the word currently held in the instruction register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cache_valid <= 1'b0;
            cached_pc   <= '0;
        end else if (accept_word) begin
            cache_valid <= 1'b1;
            cached_pc   <= mem_read_address;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= F_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            F_IDLE: begin
                if (core_is_fetch) begin
                    state_d = cache_hit ? F_FETCHED : F_FETCHING;
                end
            end
            F_FETCHING: begin
                // An acknowledge closes the request whether or not the
                // scheduler still wants the word.
                if (mem_read_ready) begin
                    state_d = core_is_fetch ? F_FETCHED : F_IDLE;
                end
            end
            F_FETCHED: begin
                if (core_is_decode || core_is_idle) begin
                    state_d = F_IDLE;
                end
            end
            default: state_d = F_IDLE;
        endcase
    end

    // Output decode: which registered outputs load this cycle.
    always_comb begin
        issue_req   = 1'b0;
        close_req   = 1'b0;
        accept_word = 1'b0;
        case (state_q)
            F_IDLE: begin
                issue_req = core_is_fetch && !cache_hit;
                close_req = !issue_req;
            end
            F_FETCHING: begin
                close_req   = mem_read_ready;
                accept_word = mem_read_ready && core_is_fetch;
            end
            F_FETCHED: begin
                close_req = 1'b1;
            end
            default: close_req = 1'b1;
        endcase
    end

    // Registered outputs; address is latched only when a request is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            instruction      <= '0;
        end else begin
            if (issue_req) begin
                mem_read_valid   <= 1'b1;
                mem_read_address <= current_pc;
            end else if (close_req) begin
                mem_read_valid   <= 1'b0;
            end
            if (accept_word) begin
                instruction <= mem_read_data;
            end
        end
    end

    assign fetcher_state = state_q;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed testbench for instruction_fetcher. Covers reset, basic fetch,
// stalled response, abandoned fetch, reset mid-fetch, spurious ready and the
// last-PC cache (behaviour depends on FETCHER_LAST_PC_CACHE_EN).
module tb_instruction_fetcher;

    logic        clk;
    logic        reset;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [2:0] C_IDLE    = 3'b000;
    localparam logic [2:0] C_FETCH   = 3'b001;
    localparam logic [2:0] C_DECODE  = 3'b010;
    localparam logic [2:0] C_EXECUTE = 3'b101;

    localparam logic [2:0] S_IDLE     = 3'b000;
    localparam logic [2:0] S_FETCHING = 3'b001;
    localparam logic [2:0] S_FETCHED  = 3'b010;

    instruction_fetcher dut (
        .clk              (clk),
        .reset            (reset),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic vld,
                             input logic [7:0] addr, input logic [15:0] ins);
        check({tag, ".state"}, 32'(fetcher_state), 32'(st));
        check({tag, ".valid"}, 32'(mem_read_valid), 32'(vld));
        check({tag, ".addr"}, 32'(mem_read_address), 32'(addr));
        check({tag, ".instr"}, 32'(instruction), 32'(ins));
    endtask

    logic [7:0] stall_pc;

    initial begin
`ifdef FETCHER_LAST_PC_CACHE_EN
        stall_pc = 8'h06;
`else
        stall_pc = 8'h05;
`endif
        reset          = 1'b1;
        core_state     = C_IDLE;
        current_pc     = 8'h00;
        mem_read_ready = 1'b0;
        mem_read_data  = 16'h0000;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_all("reset", S_IDLE, 1'b0, 8'h00, 16'h0000);

        // Basic fetch, response three cycles after the request.
        current_pc = 8'h05;
        core_state = C_FETCH;
        tick();
        check_all("basic_req", S_FETCHING, 1'b1, 8'h05, 16'h0000);
        tick();
        tick();
        check_all("basic_wait", S_FETCHING, 1'b1, 8'h05, 16'h0000);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h3123;
        tick();
        check_all("basic_done", S_FETCHED, 1'b0, 8'h05, 16'h3123);
        mem_read_ready = 1'b0;
        core_state     = C_DECODE;
        tick();
        check_all("basic_decode", S_IDLE, 1'b0, 8'h05, 16'h3123);

        // Stall: ready withheld 10 cycles while the PC moves.
        core_state = C_FETCH;
        current_pc = stall_pc;
        tick();
        current_pc = 8'h09;
        for (int i = 0; i < 10; i++) begin
            check("stall.valid", 32'(mem_read_valid), 32'd1);
            check("stall.addr", 32'(mem_read_address), 32'(stall_pc));
            tick();
        end
        check("stall.state", 32'(fetcher_state), 32'(S_FETCHING));
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h3123;
        tick();
        check_all("stall_done", S_FETCHED, 1'b0, stall_pc, 16'h3123);
        mem_read_ready = 1'b0;
        core_state     = C_DECODE;
        tick();
        check("stall_decode.state", 32'(fetcher_state), 32'(S_IDLE));

        // Abandon: scheduler drops to IDLE before the acknowledge.
        core_state = C_FETCH;
        current_pc = 8'h0A;
        tick();
        check_all("abandon_req", S_FETCHING, 1'b1, 8'h0A, 16'h3123);
        core_state = C_IDLE;
        tick();
        check_all("abandon_hold", S_FETCHING, 1'b1, 8'h0A, 16'h3123);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hA000;
        tick();
        check_all("abandon_ack", S_IDLE, 1'b0, 8'h0A, 16'h3123);
        mem_read_ready = 1'b0;
        tick();
        check_all("abandon_noreq", S_IDLE, 1'b0, 8'h0A, 16'h3123);

        // Spurious ready while idle.
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hFFFF;
        tick();
        check_all("spur_idle", S_IDLE, 1'b0, 8'h0A, 16'h3123);

        // Minimum-latency fetch: ready one cycle after valid rises.
        mem_read_ready = 1'b0;
        core_state     = C_FETCH;
        current_pc     = 8'h0B;
        tick();
        check("minlat_req.state", 32'(fetcher_state), 32'(S_FETCHING));
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h1234;
        tick();
        check_all("minlat_done", S_FETCHED, 1'b0, 8'h0B, 16'h1234);

        // Spurious ready while fetched, then FETCH must not re-request.
        core_state    = C_EXECUTE;
        mem_read_data = 16'hFFFF;
        tick();
        check_all("spur_fetched", S_FETCHED, 1'b0, 8'h0B, 16'h1234);
        mem_read_ready = 1'b0;
        core_state     = C_FETCH;
        current_pc     = 8'h0C;
        tick();
        check_all("fetched_norefetch", S_FETCHED, 1'b0, 8'h0B, 16'h1234);
        core_state = C_IDLE;
        tick();
        check("fetched_to_idle.state", 32'(fetcher_state), 32'(S_IDLE));

        // Reset in the middle of a fetch, with ready asserted the same cycle.
        core_state = C_FETCH;
        current_pc = 8'h0C;
        tick();
        check("prereset.state", 32'(fetcher_state), 32'(S_FETCHING));
        reset          = 1'b1;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hBEEF;
        tick();
        check_all("reset_mid", S_IDLE, 1'b0, 8'h00, 16'h0000);
        reset          = 1'b0;
        mem_read_ready = 1'b0;
        core_state     = C_IDLE;
        tick();
        check_all("reset_after", S_IDLE, 1'b0, 8'h00, 16'h0000);

        // Last-PC cache behaviour.
        core_state = C_FETCH;
        current_pc = 8'h07;
        tick();
        check_all("cache_first_req", S_FETCHING, 1'b1, 8'h07, 16'h0000);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h9142;
        tick();
        check_all("cache_first_done", S_FETCHED, 1'b0, 8'h07, 16'h9142);
        mem_read_ready = 1'b0;
        core_state     = C_DECODE;
        tick();
        core_state = C_FETCH;
        tick();
`ifdef FETCHER_LAST_PC_CACHE_EN
        check_all("cache_hit", S_FETCHED, 1'b0, 8'h07, 16'h9142);
`else
        check_all("cache_off_req", S_FETCHING, 1'b1, 8'h07, 16'h9142);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h9142;
        tick();
        check_all("cache_off_done", S_FETCHED, 1'b0, 8'h07, 16'h9142);
        mem_read_ready = 1'b0;
`endif
        core_state = C_DECODE;
        tick();
        core_state = C_FETCH;
        current_pc = 8'h08;
        tick();
        check_all("cache_miss_req", S_FETCHING, 1'b1, 8'h08, 16'h9142);
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h5A5A;
        tick();
        check_all("cache_miss_done", S_FETCHED, 1'b0, 8'h08, 16'h5A5A);
        mem_read_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
